// File: rtl/fp16_pkg.sv
// Shared FP16 constants and accumulator state encoding.
// Used by the accumulator RTL and by the multiplier's test benches.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;
  // Working mantissa: {hidden, man, guard, round, sticky}
  localparam int EXT_W   = MAN_W + 4;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    OUT
  } state_t;

  // exp=0 is zero and exp=EXP_MAX is forced to zero; both bypass the adder.
  function automatic logic is_zero_class(input logic [15:0] v);
    return (v[14:10] == '0) || (v[14:10] == EXP_W'(EXP_MAX));
  endfunction

endpackage

// File: rtl/fp16_align_shift.sv
// Combinational right shifter for alignment; every bit shifted out is ORed
// into the sticky LSB. Amounts of 14 and 15 leave only the sticky bit.
module fp16_align_shift
  import fp16_pkg::*;
(
  input  logic [EXT_W-1:0] data,
  input  logic [3:0]       amt,
  output logic [EXT_W-1:0] result
);

  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] lost_mask;
  logic             lost;

  assign shifted   = data >> amt;
  // For amt >= EXT_W the shift yields 0, so the mask wraps to all ones.
  assign lost_mask = (EXT_W'(1) << amt) - EXT_W'(1);
  assign lost      = |(data & lost_mask);
  assign result    = {shifted[EXT_W-1:1], shifted[0] | lost};

endmodule

// File: rtl/fp16_accum.sv
// Sequential FP16 accumulator: sums a stream of products with a multi-cycle
// align/add/normalize/round datapath and emits the sum after the last term.
module fp16_accum
  import fp16_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [15:0]        in_data_i,
  input  logic               in_last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [15:0]        out_data_o,
  output logic               out_ovf_o,
  output logic [COUNT_W-1:0] out_count_o
);

  state_t             state;
  logic [15:0]        acc;
  logic               ovf;
  logic [COUNT_W-1:0] count;
  logic               last_q;
  logic [15:0]        opb_q;
  logic [EXT_W-1:0]   work_q;
  logic [EXT_W-1:0]   aln_q;
  logic [EXP_W:0]     exp_q;
  logic               sign_q;
  logic               sub_q;

  // Alignment: order operands by magnitude, shift the smaller one.
  logic             acc_big;
  logic [15:0]      big_op;
  logic [15:0]      small_op;
  logic [EXP_W-1:0] exp_diff;
  logic [3:0]       shift_amt;
  logic [EXT_W-1:0] aligned;

  assign acc_big   = acc[14:0] >= opb_q[14:0];
  assign big_op    = acc_big ? acc : opb_q;
  assign small_op  = acc_big ? opb_q : acc;
  assign exp_diff  = big_op[14:10] - small_op[14:10];
  assign shift_amt = (exp_diff > EXP_W'(15)) ? 4'd15 : exp_diff[3:0];

  fp16_align_shift u_align_shift (
    .data   ({1'b1, small_op[MAN_W-1:0], 3'b000}),
    .amt    (shift_amt),
    .result (aligned)
  );

  logic [EXT_W:0]   sum;
  logic [EXT_W-1:0] dif;
  assign sum = {1'b0, work_q} + {1'b0, aln_q};
  assign dif = work_q - aln_q;

  // Round to nearest even on {G, R, S}; LSB is work_q[3].
  logic             rnd_up;
  logic [MAN_W+1:0] rnd_man;
  logic [EXP_W:0]   rnd_exp;
  logic [MAN_W-1:0] rnd_field;
  assign rnd_up    = work_q[2] & (work_q[1] | work_q[0] | work_q[3]);
  assign rnd_man   = {1'b0, work_q[EXT_W-1:3]} + (MAN_W+2)'(rnd_up);
  assign rnd_exp   = exp_q + (EXP_W+1)'(rnd_man[MAN_W+1]);
  assign rnd_field = rnd_man[MAN_W+1] ? rnd_man[MAN_W:1] : rnd_man[MAN_W-1:0];

  logic in_zero;
  logic acc_zero;
  assign in_zero  = is_zero_class(in_data_i);
  assign acc_zero = acc[14:10] == '0;

  // NOTE: every register here, datapath scratch included, is assigned with <=
  // and reset, so simulation ordering is deterministic and no X leaks out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      acc    <= '0;
      ovf    <= 1'b0;
      count  <= '0;
      last_q <= 1'b0;
      opb_q  <= '0;
      work_q <= '0;
      aln_q  <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      sub_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          if (count != '1) count <= count + 1'b1;
          last_q <= in_last_i;
          if (in_data_i[14:10] == EXP_W'(EXP_MAX)) ovf <= 1'b1;
          if (acc_zero || in_zero) begin
            // A zero-class input leaves acc as is (0x0000 when acc is zero too).
            if (!in_zero) acc <= in_data_i;
            state <= in_last_i ? OUT : IDLE;
          end else begin
            opb_q <= in_data_i;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          work_q <= {1'b1, big_op[MAN_W-1:0], 3'b000};
          aln_q  <= aligned;
          exp_q  <= {1'b0, big_op[14:10]};
          sign_q <= big_op[15];
          sub_q  <= acc[15] ^ opb_q[15];
          state  <= ADD;
        end
        ADD: begin
          if (!sub_q) begin
            if (sum[EXT_W]) begin
              work_q <= {sum[EXT_W:2], sum[1] | sum[0]};
              exp_q  <= exp_q + 1'b1;
            end else begin
              work_q <= sum[EXT_W-1:0];
            end
            state <= ROUND;
          end else if (dif == '0) begin
            acc   <= '0;
            state <= last_q ? OUT : IDLE;
          end else begin
            work_q <= dif;
            state  <= dif[EXT_W-1] ? ROUND : NORM;
          end
        end
        NORM: begin
          work_q <= work_q << 1;
          exp_q  <= exp_q - 1'b1;
          if (exp_q == (EXP_W+1)'(1)) begin
            acc   <= '0;
            state <= last_q ? OUT : IDLE;
          end else if (work_q[EXT_W-2]) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (rnd_exp >= (EXP_W+1)'(EXP_MAX)) begin
            acc <= '0;
            ovf <= 1'b1;
          end else begin
            acc <= {sign_q, rnd_exp[EXP_W-1:0], rnd_field};
          end
          state <= last_q ? OUT : IDLE;
        end
        OUT: if (out_ready_i) begin
          acc   <= '0;
          ovf   <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = state == IDLE;
  assign out_valid_o = state == OUT;
  assign out_data_o  = acc;
  assign out_ovf_o   = ovf;
  assign out_count_o = count;

endmodule

// File: tb/tb_fp16_accum.sv
// Directed bench for fp16_accum: hand-computed sums, latencies, handshake
// hold behaviour and asynchronous reset in the middle of normalization.
module tb_fp16_accum;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] in_data_i = 16'h0000;
  logic        in_last_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] out_data_o;
  logic        out_ovf_o;
  logic [7:0]  out_count_o;

  int tests = 0;
  int fails = 0;

  fp16_accum #(.COUNT_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ovf_o   (out_ovf_o),
    .out_count_o (out_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Present one term; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    @(negedge clk_i);
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    tests++;
    if (in_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready_o);
    end
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  // Cycles after the accepting edge until out_valid_o is seen (bounded).
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!out_valid_o && cyc < 40) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  task automatic take();
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    tests += 5;
    if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", out_valid_o); end
    if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", in_ready_o); end
    if (out_data_o !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h required 0000", out_data_o); end
    if (out_ovf_o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b required 0", out_ovf_o); end
    if (out_count_o !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d required 0", out_count_o); end
  endtask

  task automatic test_single();
    int cyc;
    send(16'h3C00, 1'b1);
    wait_result(cyc);
    tests += 4;
    if (cyc != 0) begin fails++; $display("FAIL single_latency: got %0d required 0", cyc); end
    if (out_data_o !== 16'h3C00) begin fails++; $display("FAIL single_data: got %h required 3c00", out_data_o); end
    if (out_count_o !== 8'd1) begin fails++; $display("FAIL single_count: got %0d required 1", out_count_o); end
    if (out_ovf_o !== 1'b0) begin fails++; $display("FAIL single_ovf: got %b required 0", out_ovf_o); end
    take();
    tests++;
    if (out_valid_o !== 1'b0) begin fails++; $display("FAIL single_release: out_valid=%b required 0", out_valid_o); end
  endtask

  task automatic test_simple_add();
    int cyc;
    send(16'h3C00, 1'b0);
    tests++;
    if (in_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b required 1", in_ready_o); end
    send(16'h4000, 1'b1);
    wait_result(cyc);
    tests += 4;
    if (cyc != 3) begin fails++; $display("FAIL add_latency: got %0d required 3", cyc); end
    if (out_data_o !== 16'h4200) begin fails++; $display("FAIL add_data: got %h required 4200", out_data_o); end
    if (out_count_o !== 8'd2) begin fails++; $display("FAIL add_count: got %0d required 2", out_count_o); end
    if (out_ovf_o !== 1'b0) begin fails++; $display("FAIL add_ovf: got %b required 0", out_ovf_o); end
    take();
  endtask

  // 1.0 - 0.99951171875 = 2^-11: difference sits at bit 2, 11 NORM shifts.
  task automatic test_norm_cancel();
    int cyc;
    send(16'h3C00, 1'b0);
    send(16'hBBFF, 1'b1);
    wait_result(cyc);
    tests += 3;
    if (cyc != 14) begin fails++; $display("FAIL norm_latency: got %0d required 14", cyc); end
    if (out_data_o !== 16'h1000) begin fails++; $display("FAIL norm_data: got %h required 1000", out_data_o); end
    if (out_count_o !== 8'd2) begin fails++; $display("FAIL norm_count: got %0d required 2", out_count_o); end
    take();
    send(16'h3C00, 1'b0);
    send(16'hBC00, 1'b1);
    wait_result(cyc);
    tests += 3;
    if (cyc != 2) begin fails++; $display("FAIL cancel_latency: got %0d required 2", cyc); end
    if (out_data_o !== 16'h0000) begin fails++; $display("FAIL cancel_data: got %h required 0000", out_data_o); end
    if (out_ovf_o !== 1'b0) begin fails++; $display("FAIL cancel_ovf: got %b required 0", out_ovf_o); end
    take();
  endtask

  task automatic test_round_even();
    int cyc;
    send(16'h3C00, 1'b0);
    send(16'h1000, 1'b1);
    wait_result(cyc);
    tests++;
    if (out_data_o !== 16'h3C00) begin fails++; $display("FAIL rne_tie_even: got %h required 3c00", out_data_o); end
    take();
    send(16'h3C01, 1'b0);
    send(16'h1000, 1'b1);
    wait_result(cyc);
    tests++;
    if (out_data_o !== 16'h3C02) begin fails++; $display("FAIL rne_tie_odd: got %h required 3c02", out_data_o); end
    take();
  endtask

  task automatic test_overflow();
    int cyc;
    send(16'h7BFF, 1'b0);
    send(16'h7BFF, 1'b1);
    wait_result(cyc);
    tests += 3;
    if (cyc != 3) begin fails++; $display("FAIL ovf_latency: got %0d required 3", cyc); end
    if (out_data_o !== 16'h0000) begin fails++; $display("FAIL ovf_data: got %h required 0000", out_data_o); end
    if (out_ovf_o !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b required 1", out_ovf_o); end
    take();
    tests++;
    if (out_ovf_o !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b required 0", out_ovf_o); end
    send(16'h7C00, 1'b1);
    wait_result(cyc);
    tests += 3;
    if (out_data_o !== 16'h0000) begin fails++; $display("FAIL exp31_data: got %h required 0000", out_data_o); end
    if (out_ovf_o !== 1'b1) begin fails++; $display("FAIL exp31_ovf: got %b required 1", out_ovf_o); end
    if (out_count_o !== 8'd1) begin fails++; $display("FAIL exp31_count: got %0d required 1", out_count_o); end
    take();
  endtask

  // Zeros (including exp=0 with nonzero mantissa) are absorbed by the shortcut.
  task automatic test_zero_terms();
    int cyc;
    send(16'h0000, 1'b0);
    send(16'h0123, 1'b0);
    send(16'hBC00, 1'b1);
    wait_result(cyc);
    tests += 3;
    if (out_data_o !== 16'hBC00) begin fails++; $display("FAIL zeros_data: got %h required bc00", out_data_o); end
    if (out_count_o !== 8'd3) begin fails++; $display("FAIL zeros_count: got %0d required 3", out_count_o); end
    if (out_ovf_o !== 1'b0) begin fails++; $display("FAIL zeros_ovf: got %b required 0", out_ovf_o); end
    take();
  endtask

  task automatic test_hold();
    int cyc;
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b1);
    wait_result(cyc);
    // A waiting producer must not be accepted while the result is held.
    in_valid_i = 1'b1;
    in_data_i  = 16'h3C00;
    in_last_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      tests += 4;
      if (out_data_o !== 16'h4200) begin fails++; $display("FAIL hold_data[%0d]: got %h required 4200", i, out_data_o); end
      if (in_ready_o !== 1'b0) begin fails++; $display("FAIL hold_ready[%0d]: got %b required 0", i, in_ready_o); end
      if (out_valid_o !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b required 1", i, out_valid_o); end
      if (out_count_o !== 8'd2) begin fails++; $display("FAIL hold_count[%0d]: got %0d required 2", i, out_count_o); end
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    take();
    tests += 3;
    if (in_ready_o !== 1'b1) begin fails++; $display("FAIL take_ready: got %b required 1", in_ready_o); end
    if (out_count_o !== 8'd0) begin fails++; $display("FAIL take_count: got %0d required 0", out_count_o); end
    if (out_data_o !== 16'h0000) begin fails++; $display("FAIL take_data: got %h required 0000", out_data_o); end
  endtask

  task automatic test_reset_mid_norm();
    int cyc;
    send(16'h3C00, 1'b0);
    send(16'hBBFF, 1'b1);
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    tests += 5;
    if (out_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b required 0", out_valid_o); end
    if (in_ready_o !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b required 1", in_ready_o); end
    if (out_data_o !== 16'h0000) begin fails++; $display("FAIL midrst_data: got %h required 0000", out_data_o); end
    if (out_ovf_o !== 1'b0) begin fails++; $display("FAIL midrst_ovf: got %b required 0", out_ovf_o); end
    if (out_count_o !== 8'd0) begin fails++; $display("FAIL midrst_count: got %0d required 0", out_count_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    send(16'h4000, 1'b1);
    wait_result(cyc);
    tests += 2;
    if (out_data_o !== 16'h4000) begin fails++; $display("FAIL postrst_data: got %h required 4000", out_data_o); end
    if (out_count_o !== 8'd1) begin fails++; $display("FAIL postrst_count: got %0d required 1", out_count_o); end
    take();
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    test_reset();
    test_single();
    test_simple_add();
    test_norm_cancel();
    test_round_even();
    test_overflow();
    test_zero_terms();
    test_hold();
    test_reset_mid_norm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
